// File: rtl/cram_loader.sv
// Purpose : assembles 36-bit console slices into control-store words and writes them to the control RAM.
// Latency : write strobe registered one cycle after the last slice; sequencer released HOLD_CYCLES after END.
// Backpr. : cmdReady low during the write cycle and the release countdown; offered commands wait there.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   cmdValid/cmdReady/cmdOp/cmdData   console command handshake
//                 (op 00 START, 01 DATA, 10 END, 11 SETADDR; address in the low ADDR_WIDTH data bits)
//   cramWE/cramAddr/cramData          registered control-RAM write port
//   useqHold      holds the microsequencer in reset while high
//   loaded        a load finished and the sequencer was released
//   error         sticky protocol error, cleared by START
module cram_loader #(
    parameter int CROM_WIDTH  = 108,
    parameter int ADDR_WIDTH  = 12,
    parameter int SLICES      = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [1:0]            cmdOp,
    input  logic [35:0]           cmdData,
    output logic                  cramWE,
    output logic [ADDR_WIDTH-1:0] cramAddr,
    output logic [CROM_WIDTH-1:0] cramData,
    output logic                  useqHold,
    output logic                  loaded,
    output logic                  error
);

    localparam int TOTAL_BITS = SLICES * 36;
    localparam int SCW        = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int HCW        = $clog2(HOLD_CYCLES + 1);

    localparam logic [SCW-1:0] LAST_SLICE = SCW'(SLICES - 1);
    localparam logic [HCW-1:0] HOLD_LOAD  = HCW'(HOLD_CYCLES - 1);

    localparam logic [1:0] OP_START   = 2'b00;
    localparam logic [1:0] OP_DATA    = 2'b01;
    localparam logic [1:0] OP_END     = 2'b10;
    localparam logic [1:0] OP_SETADDR = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SCW-1:0]        sliceCnt;
    logic [HCW-1:0]        holdCnt;
    logic [TOTAL_BITS-1:0] wordBuf;
    logic [TOTAL_BITS-1:0] nextWord;
    logic                  cmdAccept;

    // Ready is forced low while reset is held so nothing is taken during reset.
    assign cmdReady  = rst && ((state == ST_IDLE) || (state == ST_LOAD));
    assign cmdAccept = cmdValid && cmdReady;

    // Word buffer with the incoming slice merged in; slice 0 lands in the MSBs.
    // The last slice is written straight to cramData from here, so the write
    // strobe follows the final DATA by exactly one edge.
    always_comb begin
        nextWord = wordBuf;
        for (int n = 0; n < SLICES; n++) begin
            if (int'(sliceCnt) == n) begin
                nextWord[(SLICES-1-n)*36 +: 36] = cmdData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            sliceCnt <= '0;
            holdCnt  <= '0;
            wordBuf  <= '0;
            cramWE   <= 1'b0;
            cramAddr <= '0;
            cramData <= '0;
            useqHold <= 1'b1;
            loaded   <= 1'b0;
            error    <= 1'b0;
        end else begin
            cramWE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmdAccept) begin
                        if (cmdOp == OP_START) begin
                            useqHold <= 1'b1;
                            loaded   <= 1'b0;
                            error    <= 1'b0;
                            addr     <= cmdData[ADDR_WIDTH-1:0];
                            sliceCnt <= '0;
                            state    <= ST_LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (cmdAccept) begin
                        case (cmdOp)
                            OP_DATA: begin
                                wordBuf <= nextWord;
                                if (sliceCnt == LAST_SLICE) begin
                                    cramWE   <= 1'b1;
                                    cramAddr <= addr;
                                    cramData <= nextWord[TOTAL_BITS-1 -: CROM_WIDTH];
                                    state    <= ST_WRITE;
                                end else begin
                                    sliceCnt <= sliceCnt + 1'b1;
                                end
                            end
                            OP_SETADDR: begin
                                addr     <= cmdData[ADDR_WIDTH-1:0];
                                sliceCnt <= '0;
                            end
                            OP_START: begin
                                addr     <= cmdData[ADDR_WIDTH-1:0];
                                sliceCnt <= '0;
                                error    <= 1'b0;
                            end
                            default: begin // OP_END
                                // A partial word at END is a protocol error but
                                // the release still proceeds.
                                if (sliceCnt != '0) begin
                                    error <= 1'b1;
                                end
                                sliceCnt <= '0;
                                holdCnt  <= HOLD_LOAD;
                                state    <= ST_RELEASE;
                            end
                        endcase
                    end
                end

                ST_WRITE: begin
                    // cramAddr keeps the written address; only the running
                    // address advances, wrapping (and flagging) past all-ones.
                    if (&addr) begin
                        error <= 1'b1;
                    end
                    addr     <= addr + 1'b1;
                    sliceCnt <= '0;
                    state    <= ST_LOAD;
                end

                ST_RELEASE: begin
                    // Countdown was loaded with HOLD_CYCLES-1 at END, so the
                    // hold drops on the HOLD_CYCLES-th edge after END.
                    if (holdCnt == '0) begin
                        useqHold <= 1'b0;
                        loaded   <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        holdCnt <= holdCnt - 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cram_loader.sv
// Bench for cram_loader: directed scenarios with literal expectations, then
// randomized command streams checked every cycle against a queue-based model.
module tb_cram_loader;

    logic         clk;
    logic         rst;
    logic         cmdValid;
    logic         cmdReady;
    logic [1:0]   cmdOp;
    logic [35:0]  cmdData;
    logic         cramWE;
    logic [11:0]  cramAddr;
    logic [107:0] cramData;
    logic         useqHold;
    logic         loaded;
    logic         error;

    cram_loader #(
        .CROM_WIDTH (108),
        .ADDR_WIDTH (12),
        .SLICES     (3),
        .HOLD_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmdValid(cmdValid),
        .cmdReady(cmdReady),
        .cmdOp   (cmdOp),
        .cmdData (cmdData),
        .cramWE  (cramWE),
        .cramAddr(cramAddr),
        .cramData(cramData),
        .useqHold(useqHold),
        .loaded  (loaded),
        .error   (error)
    );

    localparam logic [1:0] START   = 2'b00;
    localparam logic [1:0] DATA    = 2'b01;
    localparam logic [1:0] ENDC    = 2'b10;
    localparam logic [1:0] SETADDR = 2'b11;

    typedef struct {
        logic [11:0]  a;
        logic [107:0] d;
    } wr_t;

    int  nVec = 0;
    int  nErr = 0;
    int  cyc  = 0;
    int  lastAcc;
    bit  chkEn = 0;
    wr_t dutWrites[$];

    // ---------------- behavioural model ----------------
    bit           mLoading;
    logic [35:0]  mSl[$];
    int           mAddr;
    bit           mWrPend;
    int           mRel;
    bit           eWE;
    logic [11:0]  eAddr;
    logic [107:0] eData;
    bit           eHold;
    bit           eLoaded;
    bit           eErr;

    task automatic modelReset();
        mLoading = 0;
        mSl.delete();
        mAddr   = 0;
        mWrPend = 0;
        mRel    = 0;
        eWE     = 0;
        eAddr   = '0;
        eData   = '0;
        eHold   = 1;
        eLoaded = 0;
        eErr    = 0;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst === 1'b1) begin
            eWE = 0;
            if (mWrPend) begin
                mWrPend = 0;
                if (mAddr == 4095) eErr = 1;
                mAddr = (mAddr + 1) % 4096;
            end else if (mRel > 0) begin
                mRel--;
                if (mRel == 0) begin
                    eHold    = 0;
                    eLoaded  = 1;
                    mLoading = 0;
                end
            end else if (cmdValid) begin
                if (!mLoading) begin
                    if (cmdOp == START) begin
                        mLoading = 1;
                        mSl.delete();
                        mAddr   = int'(cmdData[11:0]);
                        eHold   = 1;
                        eLoaded = 0;
                        eErr    = 0;
                    end else begin
                        eErr = 1;
                    end
                end else begin
                    case (cmdOp)
                        DATA: begin
                            mSl.push_back(cmdData);
                            if (mSl.size() == 3) begin
                                eWE     = 1;
                                eAddr   = 12'(mAddr);
                                eData   = {mSl[0], mSl[1], mSl[2]};
                                mWrPend = 1;
                                mSl.delete();
                            end
                        end
                        SETADDR: begin
                            mAddr = int'(cmdData[11:0]);
                            mSl.delete();
                        end
                        START: begin
                            mAddr = int'(cmdData[11:0]);
                            mSl.delete();
                            eErr = 0;
                        end
                        default: begin
                            if (mSl.size() != 0) eErr = 1;
                            mSl.delete();
                            mRel = 4;
                        end
                    endcase
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chkEn) begin
            chk("cmdReady", 128'(cmdReady), 128'((rst === 1'b1) && !mWrPend && (mRel == 0)));
            chk("cramWE",   128'(cramWE),   128'(eWE));
            chk("cramAddr", 128'(cramAddr), 128'(eAddr));
            chk("cramData", 128'(cramData), 128'(eData));
            chk("useqHold", 128'(useqHold), 128'(eHold));
            chk("loaded",   128'(loaded),   128'(eLoaded));
            chk("error",    128'(error),    128'(eErr));
            if (cramWE === 1'b1) dutWrites.push_back('{cramAddr, cramData});
        end
    end

    // ---------------- stimulus helpers ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        cmdValid = 1'b0;
        cmdOp    = 2'($urandom);
        cmdData  = {4'($urandom), 32'($urandom)};
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a command and holds it until the loader takes it.
    task automatic sendCmd(input logic [1:0] op, input logic [35:0] d);
        bit done;
        bit rdy;
        done     = 0;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = d;
        for (int w = 0; w < 40 && !done; w++) begin
            rdy = cmdReady;
            @(posedge clk);
            #1;
            if (rdy) begin
                done    = 1;
                lastAcc = cyc;
            end
        end
        chk("accept_within_budget", 128'(done), 128'(1));
        cmdValid = 1'b0;
    endtask

    task automatic sendWord(input logic [35:0] s0, input logic [35:0] s1, input logic [35:0] s2);
        sendCmd(DATA, s0);
        sendCmd(DATA, s1);
        sendCmd(DATA, s2);
    endtask

    task automatic doReset();
        rst = 1'b0;
        modelReset();
        #1;
        chk("rst_async_hold",  128'(useqHold), 128'(1));
        chk("rst_ready_low",   128'(cmdReady), 128'(0));
        chk("rst_loaded_low",  128'(loaded),   128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int endAcc;
        int dataAcc;
        int fellCyc;
        logic [35:0] s0;
        logic [35:0] s1;
        logic [35:0] s2;

        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdOp    = 2'b00;
        cmdData  = '0;
        modelReset();
        #1;
        rst = 1'b0;
        #2;
        chkEn = 1;
        chk("reset_useqHold", 128'(useqHold), 128'(1));
        chk("reset_loaded",   128'(loaded),   128'(0));
        chk("reset_cramWE",   128'(cramWE),   128'(0));
        chk("reset_cmdReady", 128'(cmdReady), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ready_after_reset", 128'(cmdReady), 128'(1));

        // DATA in IDLE: error, no write
        sendCmd(DATA, 36'h123456789);
        idle(2);
        chk("idle_data_error", 128'(error), 128'(1));
        chk("idle_data_nowrite", 128'(dutWrites.size()), 128'(0));

        // First word at o0000, second at o0001
        sendCmd(START, 36'o0000);
        chk("start_clears_error", 128'(error), 128'(0));
        sendWord(36'h111111111, 36'h222222222, 36'h333333333);
        dataAcc = lastAcc;
        idle(2);
        chk("w0_count", 128'(dutWrites.size()), 128'(1));
        if (dutWrites.size() >= 1) begin
            chk("w0_addr", 128'(dutWrites[0].a), 128'(12'o0000));
            chk("w0_data", 128'(dutWrites[0].d), 128'(108'h111111111222222222333333333));
        end
        sendWord(36'hAAAAAAAAA, 36'h555555555, 36'h0F0F0F0F0);
        idle(2);
        chk("w1_count", 128'(dutWrites.size()), 128'(2));
        if (dutWrites.size() >= 2) begin
            chk("w1_addr", 128'(dutWrites[1].a), 128'(12'o0001));
            chk("w1_data", 128'(dutWrites[1].d), 128'(108'hAAAAAAAAA5555555550F0F0F0F0));
        end

        // Address wrap at o7777
        sendCmd(SETADDR, 36'o7777);
        sendWord(36'h444444444, 36'h555555555, 36'h666666666);
        idle(2);
        chk("wrap_error", 128'(error), 128'(1));
        sendWord(36'h777777777, 36'h888888888, 36'h999999999);
        idle(2);
        chk("wrap_count", 128'(dutWrites.size()), 128'(4));
        if (dutWrites.size() >= 4) begin
            chk("wrap_addr_hi", 128'(dutWrites[2].a), 128'(12'o7777));
            chk("wrap_addr_lo", 128'(dutWrites[3].a), 128'(12'o0000));
        end

        // Partial word then END: no write, error, release after 4 edges
        sendCmd(START, 36'o0100);
        chk("restart_clears_error", 128'(error), 128'(0));
        base = dutWrites.size();
        sendCmd(DATA, 36'h0DEADBEEF);
        sendCmd(DATA, 36'h0CAFEF00D);
        sendCmd(ENDC, 36'h0);
        endAcc = lastAcc;
        chk("partial_end_error", 128'(error), 128'(1));
        fellCyc = -1;
        for (int w = 0; w < 20 && fellCyc < 0; w++) begin
            @(posedge clk);
            #1;
            if (useqHold == 1'b0) fellCyc = cyc;
        end
        chk("hold_fall_delay", 128'(fellCyc - endAcc), 128'(4));
        chk("loaded_after_end", 128'(loaded), 128'(1));
        chk("partial_nowrite", 128'(dutWrites.size()), 128'(base));

        // Valid held through WRITE and RELEASE: commands stall
        sendCmd(START, 36'o0200);
        sendWord(36'h010203040, 36'h050607080, 36'h090A0B0C0);
        dataAcc = lastAcc;
        sendCmd(ENDC, 36'h0);
        endAcc = lastAcc;
        chk("end_stalled_by_write", 128'(endAcc - dataAcc), 128'(2));
        sendCmd(DATA, 36'h0);
        chk("data_stalled_by_release", 128'(lastAcc - endAcc), 128'(5));
        chk("idle_data_after_release", 128'(error), 128'(1));
        chk("stall_hold_released", 128'(useqHold), 128'(0));

        // Asynchronous reset while released, then mid-word
        doReset();
        sendCmd(START, 36'o1234);
        base = dutWrites.size();
        sendCmd(DATA, 36'h111111111);
        sendCmd(DATA, 36'h222222222);
        doReset();
        idle(2);
        chk("midword_reset_nowrite", 128'(dutWrites.size()), 128'(base));
        sendCmd(START, 36'o1234);
        sendWord(36'h0ABCDEF01, 36'h123456789, 36'h987654321);
        idle(2);
        chk("post_reset_count", 128'(dutWrites.size()), 128'(base + 1));
        if (dutWrites.size() >= base + 1) begin
            chk("post_reset_addr", 128'(dutWrites[base].a), 128'(12'o1234));
            chk("post_reset_data", 128'(dutWrites[base].d), 128'(108'h0ABCDEF01123456789987654321));
        end

        // Randomized streams
        for (int i = 0; i < 500; i++) begin
            int r;
            r  = int'($urandom_range(0, 99));
            s0 = ($urandom_range(0, 1) == 1) ? 36'(4088 + $urandom_range(0, 7)) : rnd36();
            if (r < 55)       sendCmd(DATA, rnd36());
            else if (r < 65)  sendCmd(ENDC, rnd36());
            else if (r < 77)  sendCmd(START, s0);
            else if (r < 87)  sendCmd(SETADDR, s0);
            else if (r < 98)  idle(int'($urandom_range(1, 3)));
            else              doReset();
        end
        s1 = rnd36();
        s2 = rnd36();
        sendCmd(START, 36'o7776);
        sendWord(s1, s2, s1 ^ s2);
        sendCmd(ENDC, 36'h0);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
